// File: rtl/even_parity_pkg.sv
// Shared definitions for the even-parity serial receiver: FSM encoding,
// error-counter saturation value and the running-parity helper.
package even_parity_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DATA   = 2'b01,
        ST_PARITY = 2'b10
    } state_e;

    localparam logic [7:0] ERR_CNT_SAT = 8'hFF;

    // Fold one received bit into the running even-parity accumulator.
    function automatic logic parity_acc(input logic acc, input logic bit_in);
        return acc ^ bit_in;
    endfunction

endpackage

// File: rtl/parity_err_counter.sv
// Saturating 8-bit parity-error counter; clear wins over a same-cycle increment.
module parity_err_counter
    import even_parity_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [7:0] count_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Next count: clear first, else increment unless already at the ceiling.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = 8'h00;
        end else if (inc_i && (count_q != ERR_CNT_SAT)) begin
            count_d = count_q + 8'h01;
        end else begin
            count_d = count_q;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 8'h00;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/even_parity_rx_check.sv
// Serial even-parity frame receiver: DATA_W data bits LSB first followed by
// one parity bit, framed by s_sof. Optional error counter is built only when
// the macro PARITY_ERR_CNT_EN is defined; otherwise err_count reads 0.
module even_parity_rx_check
    import even_parity_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic              s_bit,
    input  logic              s_sof,
    input  logic              err_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              parity_err,
    output logic              busy,
    output logic [7:0]        err_count
);

    localparam int IDX_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                xor_q, xor_d;
    logic [DATA_W-1:0]   buf_q, buf_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                perr_q, perr_d;
    logic                ov_q, ov_d;
    logic                busy_q, busy_d;
    logic                err_inc_s;

    // Frame assembly: start/restart on s_sof, collect data bits, close on parity.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        xor_d      = xor_q;
        buf_d      = buf_q;
        data_out_d = data_out_q;
        perr_d     = perr_q;
        ov_d       = 1'b0;
        if (s_valid && s_sof) begin
            // A start bit always begins a fresh frame, abandoning any partial one.
            buf_d    = {DATA_W{1'b0}};
            buf_d[0] = s_bit;
            idx_d    = IDX_W'(1);
            xor_d    = s_bit;
            state_d  = ST_DATA;
        end else if (s_valid) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_DATA: begin
                    buf_d[idx_q] = s_bit;
                    xor_d        = parity_acc(xor_q, s_bit);
                    if (idx_q == IDX_W'(DATA_W - 1)) begin
                        idx_d   = {IDX_W{1'b0}};
                        state_d = ST_PARITY;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    data_out_d = buf_q;
                    perr_d     = parity_acc(xor_q, s_bit);
                    ov_d       = 1'b1;
                    idx_d      = {IDX_W{1'b0}};
                    xor_d      = 1'b0;
                    state_d    = ST_IDLE;
                end
                default: begin
                    idx_d   = {IDX_W{1'b0}};
                    xor_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            // Gap cycle: everything holds.
            state_d = state_q;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers, synchronous reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= {IDX_W{1'b0}};
            xor_q      <= 1'b0;
            buf_q      <= {DATA_W{1'b0}};
            data_out_q <= {DATA_W{1'b0}};
            perr_q     <= 1'b0;
            ov_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            xor_q      <= xor_d;
            buf_q      <= buf_d;
            data_out_q <= data_out_d;
            perr_q     <= perr_d;
            ov_q       <= ov_d;
            busy_q     <= busy_d;
        end
    end

    // Count on the completing edge so err_count is current while out_valid is high.
    assign err_inc_s = ov_d & perr_d;

`ifdef PARITY_ERR_CNT_EN
    parity_err_counter u_err_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (err_clr),
        .inc_i   (err_inc_s),
        .count_o (err_count)
    );
`else
    logic unused_cnt_s;
    assign unused_cnt_s = err_clr ^ err_inc_s;
    assign err_count    = 8'h00;
`endif

    assign data_out   = data_out_q;
    assign out_valid  = ov_q;
    assign parity_err = perr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_even_parity_rx_check.sv
// Self-checking bench for even_parity_rx_check. Expected frames are queued as
// their parity bit is driven and compared when out_valid appears.
module tb_even_parity_rx_check;

    localparam int DW = 8;

`ifdef PARITY_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_bit = 1'b0;
    logic          s_sof = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] data_out;
    logic          out_valid;
    logic          parity_err;
    logic          busy;
    logic [7:0]    err_count;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic [7:0] cnt;
    } exp_t;

    exp_t   sb[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     exp_cnt = 0;
    int     ov_seen = 0;
    longint cyc = 0;
    longint ov_cyc_last = -1;
    longint ov_cyc_prev = -1;

    even_parity_rx_check #(.DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_bit      (s_bit),
        .s_sof      (s_sof),
        .err_clr    (err_clr),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .parity_err (parity_err),
        .busy       (busy),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every out_valid pulse must match the oldest queued frame.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            ov_seen++;
            ov_cyc_prev = ov_cyc_last;
            ov_cyc_last = cyc;
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_out_valid data_out=%h (no frame expected)", data_out);
            end else begin
                e = sb.pop_front();
                n_cmp++;
                if (data_out !== e.data) begin
                    n_bad++;
                    $display("FAIL frame_data got=%h exp=%h", data_out, e.data);
                end
                n_cmp++;
                if (parity_err !== e.perr) begin
                    n_bad++;
                    $display("FAIL frame_perr data=%h got=%b exp=%b", e.data, parity_err, e.perr);
                end
                n_cmp++;
                if (err_count !== e.cnt) begin
                    n_bad++;
                    $display("FAIL frame_err_count got=%0d exp=%0d", err_count, e.cnt);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input logic sof, input logic b, input logic clr);
        s_valid = 1'b1; s_sof = sof; s_bit = b; err_clr = clr;
        @(posedge clk); #1;
        s_valid = 1'b0; s_sof = 1'b0; s_bit = 1'b0; err_clr = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Drive one frame; gap_at inserts one idle cycle before that data bit.
    task automatic send_frame(input logic [7:0] d, input logic par, input int gap_at, input logic clr_par);
        exp_t e;
        for (int i = 0; i < DW; i++) begin
            if (i == gap_at) idle_cycles(1);
            send_bit(i == 0, d[i], 1'b0);
        end
        e.data = d;
        e.perr = (^d) ^ par;
        if (CNT_EN) begin
            if (clr_par) exp_cnt = 0;
            else if (e.perr && exp_cnt < 255) exp_cnt++;
        end
        e.cnt = 8'(exp_cnt);
        sb.push_back(e);
        send_bit(1'b0, par, clr_par);
    endtask

    // out_valid must be high in the cycle right after the parity bit.
    task automatic finish_frame();
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL out_valid_latency got=%b exp=1", out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_cycles(3);
        n_cmp++;
        if ({data_out, out_valid, parity_err, busy, err_count} !== '0) begin
            n_bad++;
            $display("FAIL reset_state data=%h ov=%b perr=%b busy=%b cnt=%0d exp all 0",
                     data_out, out_valid, parity_err, busy, err_count);
        end
        rst = 1'b0;
        idle_cycles(2);
        n_cmp++;
        if ({out_valid, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL post_reset_idle ov=%b busy=%b exp 0 0", out_valid, busy);
        end
    endtask

    task automatic test_basic();
        send_frame(8'hA6, 1'b0, 3, 1'b0);
        finish_frame();
        idle_cycles(3);
        n_cmp++;
        if ({data_out, parity_err} !== {8'hA6, 1'b0}) begin
            n_bad++;
            $display("FAIL basic_hold data=%h perr=%b exp a6 0", data_out, parity_err);
        end
        n_cmp++;
        if (err_count !== 8'(exp_cnt)) begin
            n_bad++;
            $display("FAIL basic_err_count got=%0d exp=%0d", err_count, exp_cnt);
        end
    endtask

    task automatic test_parity();
        send_frame(8'hD9, 1'b1, -1, 1'b0);
        finish_frame();
        send_frame(8'hD9, 1'b0, -1, 1'b0);
        finish_frame();
        n_cmp++;
        if (err_count !== (CNT_EN ? 8'd1 : 8'd0)) begin
            n_bad++;
            $display("FAIL parity_err_count got=%0d exp=%0d", err_count, CNT_EN ? 1 : 0);
        end
    endtask

    // Second frame starts in the out_valid cycle of the first and carries one
    // idle gap, so the two pulses land DW+2 = 10 cycles apart.
    task automatic test_back_to_back();
        int seen0;
        seen0 = ov_seen;
        send_frame(8'h5A, 1'b0, -1, 1'b0);
        send_frame(8'h3C, 1'b1, 4, 1'b0);
        finish_frame();
        n_cmp++;
        if (ov_seen - seen0 != 2) begin
            n_bad++;
            $display("FAIL b2b_pulses got=%0d exp=2", ov_seen - seen0);
        end
        n_cmp++;
        if (ov_cyc_last - ov_cyc_prev != 64'd10) begin
            n_bad++;
            $display("FAIL b2b_spacing got=%0d exp=10", ov_cyc_last - ov_cyc_prev);
        end
    endtask

    task automatic test_abort();
        int seen0;
        seen0 = ov_seen;
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_busy got=%b exp=1", busy);
        end
        send_frame(8'h0E, 1'b1, -1, 1'b0);
        finish_frame();
        idle_cycles(2);
        n_cmp++;
        if (ov_seen - seen0 != 1) begin
            n_bad++;
            $display("FAIL abort_pulses got=%0d exp=1", ov_seen - seen0);
        end
    endtask

    task automatic test_reset_mid();
        send_bit(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({out_valid, data_out, err_count, busy} !== '0) begin
                n_bad++;
                $display("FAIL reset_mid_%0d ov=%b data=%h cnt=%0d busy=%b exp all 0",
                         k, out_valid, data_out, err_count, busy);
            end
        end
        rst = 1'b0;
        exp_cnt = 0;
        idle_cycles(1);
        n_cmp++;
        if ({out_valid, data_out, err_count, busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_after ov=%b data=%h cnt=%0d busy=%b exp all 0",
                     out_valid, data_out, err_count, busy);
        end
        send_frame(8'h01, 1'b1, -1, 1'b0);
        finish_frame();
    endtask

    task automatic test_saturate();
        logic [7:0] d;
        for (int i = 0; i < 260; i++) begin
            d = 8'($urandom);
            send_frame(d, (^d) ^ 1'b1, -1, 1'b0);
        end
        finish_frame();
        n_cmp++;
        if (err_count !== (CNT_EN ? 8'd255 : 8'd0)) begin
            n_bad++;
            $display("FAIL sat_err_count got=%0d exp=%0d", err_count, CNT_EN ? 255 : 0);
        end
        d = 8'($urandom);
        send_frame(d, (^d) ^ 1'b1, -1, 1'b1);
        finish_frame();
        n_cmp++;
        if (err_count !== 8'd0) begin
            n_bad++;
            $display("FAIL clr_priority got=%0d exp=0", err_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_saturate();
        idle_cycles(3);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
